// File: rtl/cla_add_arbiter_if.sv
// Requester/response bus of the shared CLA adder arbiter.
interface cla_add_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ*WIDTH-1:0] a_in;
    logic [NUM_REQ*WIDTH-1:0] b_in;
    logic                     busy;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_cout;
    logic                     rsp_ovfl;

    modport master (
        output req, a_in, b_in, rsp_ready,
        input  gnt, busy, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovfl
    );

    modport slave (
        input  req, a_in, b_in, rsp_ready,
        output gnt, busy, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovfl
    );
endinterface

// File: rtl/cla_add_arbiter.sv
// One shared 16-bit CLA time-multiplexed among NUM_REQ requesters (IDLE->CALC->RESP).
// Define CLA_ARB_RR_EN for round-robin arbitration; default is fixed lowest-index priority.

module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       grp_g,
    output logic       grp_p
);
    logic [3:0] g, p, c;

    // Group terms kept free of cin so the upper lookahead level has no false loop.
    always_comb begin
        logic acc;
        g   = a & b;
        p   = a ^ b;
        acc = 1'b0;
        for (int i = 0; i < 4; i++) acc = g[i] | (p[i] & acc);
        grp_g = acc;
        grp_p = &p;
    end

    always_comb begin
        logic acc;
        acc = cin;
        c   = '0;
        for (int i = 0; i < 4; i++) begin
            c[i] = acc;
            acc  = g[i] | (p[i] & acc);
        end
        sum = p ^ c;
    end
endmodule

module cla_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [3:0] gg, gp;
    logic [4:0] gc;

    genvar j;
    generate
        for (j = 0; j < 4; j++) begin : g_grp
            cla_4bit u_grp (
                .a     (a[4*j +: 4]),
                .b     (b[4*j +: 4]),
                .cin   (gc[j]),
                .sum   (sum[4*j +: 4]),
                .grp_g (gg[j]),
                .grp_p (gp[j])
            );
        end
    endgenerate

    always_comb begin
        logic acc;
        acc = cin;
        gc  = '0;
        for (int i = 0; i < 4; i++) begin
            gc[i] = acc;
            acc   = gg[i] | (gp[i] & acc);
        end
        gc[4] = acc;
    end

    assign cout = gc[4];
endmodule

module cla_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    cla_add_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t             state;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [ID_W-1:0]    op_id;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_id;
    logic               arb_hit;
    logic [WIDTH-1:0]   cla_sum;
    logic               cla_cout;
    logic               cla_ovfl;
    logic               busy_q, valid_q, cout_q, ovfl_q;
    logic [ID_W-1:0]    id_q;
    logic [WIDTH-1:0]   sum_q;

`ifdef CLA_ARB_RR_EN
    logic [ID_W-1:0] rr_ptr;

    // Search begins one past the last accepted requester.
    always_comb begin
        int idx;
        arb_gnt = '0;
        arb_id  = '0;
        arb_hit = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!arb_hit && bus.req[ID_W'(idx)]) begin
                arb_hit              = 1'b1;
                arb_id               = ID_W'(idx);
                arb_gnt[ID_W'(idx)]  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        arb_gnt = '0;
        arb_id  = '0;
        arb_hit = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!arb_hit && bus.req[ID_W'(i)]) begin
                arb_hit            = 1'b1;
                arb_id             = ID_W'(i);
                arb_gnt[ID_W'(i)]  = 1'b1;
            end
        end
    end
`endif

    cla_16bit u_cla (
        .a    (op_a),
        .b    (op_b),
        .cin  (1'b0),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    assign cla_ovfl = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (cla_sum[WIDTH-1] != op_a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            id_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovfl_q  <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            op_id   <= '0;
`ifdef CLA_ARB_RR_EN
            rr_ptr  <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            case (state)
                IDLE: if (arb_hit) begin
                    op_a   <= bus.a_in[arb_id*WIDTH +: WIDTH];
                    op_b   <= bus.b_in[arb_id*WIDTH +: WIDTH];
                    op_id  <= arb_id;
                    busy_q <= 1'b1;
                    state  <= CALC;
`ifdef CLA_ARB_RR_EN
                    rr_ptr <= arb_id;
`endif
                end
                CALC: begin
                    sum_q   <= cla_sum;
                    cout_q  <= cla_cout;
                    ovfl_q  <= cla_ovfl;
                    id_q    <= op_id;
                    valid_q <= 1'b1;
                    state   <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Grants are offered only while idle and out of reset.
    assign bus.gnt       = (state == IDLE && rst_n) ? arb_gnt : '0;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;
    assign bus.rsp_ovfl  = ovfl_q;
endmodule

// File: tb/tb_cla_add_arbiter.sv
// Self-checking bench: directed vectors, multi-cycle corner sequences and a random scoreboard run.
module tb_cla_add_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TOT = 2024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla_add_arbiter_if #(.NUM_REQ(N), .WIDTH(16)) bus ();

    cla_add_arbiter #(.NUM_REQ(N), .WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef CLA_ARB_RR_EN
        for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
`else
        for (int k = 0; k < N; k++) if (r[k]) return k;
`endif
        return -1;
    endfunction

    // Reference model: one outstanding transaction, result due two cycles after its grant.
    int       cyc = 0;
    int       rr = N - 1;
    logic     m_pend = 1'b0;
    int       m_gcyc = 0;
    logic [IDW-1:0] m_id = '0;
    logic [15:0]    m_sum = '0;
    logic     m_cout = 1'b0, m_ovfl = 1'b0;
    int       n_grant = 0, n_hs = 0;

    always @(negedge clk) begin : mon
        int w, sa, sb, ss;
        logic [N-1:0] eg;
        logic [15:0] a, b;
        logic [31:0] s;
        logic ev;
        cyc++;
        w  = (rst_n && !m_pend) ? pick(bus.req, rr) : -1;
        eg = (w >= 0) ? (N'(1) << w) : '0;
        ev = m_pend && (cyc >= m_gcyc + 2);
        chk("gnt", 32'(bus.gnt), 32'(eg));
        chk("busy", 32'(bus.busy), 32'(m_pend && (cyc > m_gcyc)));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
        if (ev) begin
            chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
            chk("rsp_sum", 32'(bus.rsp_sum), 32'(m_sum));
            chk("rsp_cout", 32'(bus.rsp_cout), 32'(m_cout));
            chk("rsp_ovfl", 32'(bus.rsp_ovfl), 32'(m_ovfl));
        end
        if (!rst_n) begin
            m_pend = 1'b0;
            rr     = N - 1;
        end else if (w >= 0) begin
            a      = bus.a_in[16*w +: 16];
            b      = bus.b_in[16*w +: 16];
            s      = 32'(a) + 32'(b);
            sa     = int'($signed(a));
            sb     = int'($signed(b));
            ss     = sa + sb;
            m_sum  = s[15:0];
            m_cout = s[16];
            m_ovfl = (ss > 32767) || (ss < -32768);
            m_id   = IDW'(w);
            m_pend = 1'b1;
            m_gcyc = cyc;
            rr     = w;
            n_grant++;
        end else if (ev && bus.rsp_ready) begin
            m_pend = 1'b0;
            n_hs++;
        end
    end

    task automatic xact(input int i, input logic [15:0] a, input logic [15:0] b,
                        output logic [IDW-1:0] id, output logic [15:0] s,
                        output logic co, output logic ov, output int lat);
        bit got;
        bus.req[i] = 1'b1;
        bus.a_in[16*i +: 16] = a;
        bus.b_in[16*i +: 16] = b;
        got = 0; lat = -1; id = '0; s = '0; co = 1'b0; ov = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.gnt[i]) got = 1;
            @(posedge clk); #1;
        end
        bus.req[i] = 1'b0;
        chk("grant_seen", 32'(got), 32'd1);
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got = 1; lat = c + 1;
                id = bus.rsp_id; s = bus.rsp_sum; co = bus.rsp_cout; ov = bus.rsp_ovfl;
            end
            @(posedge clk); #1;
        end
        chk("rsp_seen", 32'(got), 32'd1);
    endtask

    task automatic drain();
        bus.req = '0;
        bus.rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int          idx;
        logic [15:0] a, b, sum;
        logic        cout, ovfl;
    } vec_t;

    vec_t vt[7];

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [IDW-1:0] id;
        logic [15:0] s;
        logic co, ov;
        int lat, nv, loaded, dropped, hs0, gr0, idx0;
        logic [IDW-1:0] ids[5];
        int vcyc[5];
        logic [N-1:0] g;
        bit got;

        vt[0] = '{0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0};
        vt[1] = '{2, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{2, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        vt[3] = '{2, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        vt[4] = '{3, 16'h1234, 16'h0FED, 16'h2221, 1'b0, 1'b0};
        vt[5] = '{1, 16'h8000, 16'hFFFF, 16'h7FFF, 1'b1, 1'b1};
        vt[6] = '{0, 16'h7FFF, 16'h7FFF, 16'hFFFE, 1'b0, 1'b1};

        bus.req = '0; bus.a_in = '0; bus.b_in = '0; bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("reset_gnt", 32'(bus.gnt), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_id", 32'(bus.rsp_id), 32'd0);
        chk("reset_sum", 32'(bus.rsp_sum), 32'd0);
        chk("reset_cout", 32'(bus.rsp_cout), 32'd0);
        chk("reset_ovfl", 32'(bus.rsp_ovfl), 32'd0);
        @(posedge clk); #1;

        // Directed single transactions.
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            xact(vt[k].idx, vt[k].a, vt[k].b, id, s, co, ov, lat);
            chk("vec_latency", 32'(lat), 32'd2);
            chk("vec_id", 32'(id), 32'(vt[k].idx));
            chk("vec_sum", 32'(s), 32'(vt[k].sum));
            chk("vec_cout", 32'(co), 32'(vt[k].cout));
            chk("vec_ovfl", 32'(ov), 32'(vt[k].ovfl));
        end
        @(negedge clk);
        chk("vec_back_idle", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;

        // All requesters held: arbitration order and 3-cycle issue spacing.
        drain();
        do_reset();
        for (int i = 0; i < N; i++) begin
            bus.a_in[16*i +: 16] = 16'(i * 256 + 1);
            bus.b_in[16*i +: 16] = 16'h0010;
        end
        bus.req = '1;
        nv = 0;
        for (int c = 0; c < 40 && nv < 5; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                ids[nv] = bus.rsp_id; vcyc[nv] = c; nv++;
            end
            @(posedge clk); #1;
        end
        bus.req = '0;
        chk("hold_count", 32'(nv), 32'd5);
        for (int k = 0; k < nv; k++) begin
`ifdef CLA_ARB_RR_EN
            chk("hold_id", 32'(ids[k]), 32'(k % N));
`else
            chk("hold_id", 32'(ids[k]), 32'd0);
`endif
            if (k > 0) chk("hold_spacing", 32'(vcyc[k] - vcyc[k-1]), 32'd3);
        end
        drain();

        // Response stall with other requests pending.
        bus.rsp_ready = 1'b0;
        bus.req[1] = 1'b1;
        bus.a_in[31:16] = 16'h1234;
        bus.b_in[31:16] = 16'h4321;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.gnt[1]) got = 1;
            @(posedge clk); #1;
        end
        chk("stall_grant", 32'(got), 32'd1);
        bus.req = 4'b1101;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) got = 1;
            @(posedge clk); #1;
        end
        chk("stall_valid", 32'(got), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_hold_sum", 32'(bus.rsp_sum), 32'h5555);
            chk("stall_hold_id", 32'(bus.rsp_id), 32'd1);
            chk("stall_gnt", 32'(bus.gnt), 32'd0);
            chk("stall_busy", 32'(bus.busy), 32'd1);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_hs_valid", 32'(bus.rsp_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_after_valid", 32'(bus.rsp_valid), 32'd0);
`ifdef CLA_ARB_RR_EN
        chk("stall_next_gnt", 32'(bus.gnt), 32'b0100);
`else
        chk("stall_next_gnt", 32'(bus.gnt), 32'b0001);
`endif
        @(posedge clk); #1;
        drain();

        // Reset while the adder is mid-transaction.
        bus.req[1] = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.gnt[1]) got = 1;
            @(posedge clk); #1;
        end
        chk("rst_grant", 32'(got), 32'd1);
        bus.req = '0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.req = '1;
        @(negedge clk);
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_first_gnt", 32'(bus.gnt), 32'b0001);
        @(posedge clk); #1;
        drain();

        // Sweep plus random operands, random requesters and random back-pressure.
        loaded = 0; dropped = 0; hs0 = n_hs; gr0 = n_grant;
        for (int c = 0; c < 60000 && (loaded < TOT || bus.req != '0); c++) begin
            @(negedge clk);
            g = bus.gnt & bus.req;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    bus.req[i] = 1'b0;
                end else if (bus.req[i]) begin
                    if ($urandom_range(63) == 0) begin
                        bus.req[i] = 1'b0;
                        dropped++;
                    end
                end else if (loaded < TOT && $urandom_range(3) == 0) begin
                    idx0 = loaded;
                    if (idx0 < 1024) begin
                        bus.a_in[16*i +: 16] = 16'((idx0 / 32) * 16 + (idx0 % 7));
                        bus.b_in[16*i +: 16] = 16'((idx0 % 32) * 16 + (idx0 % 5));
                    end else begin
                        bus.a_in[16*i +: 16] = 16'($urandom);
                        bus.b_in[16*i +: 16] = 16'($urandom);
                    end
                    bus.req[i] = 1'b1;
                    loaded++;
                end
            end
            bus.rsp_ready = ($urandom_range(2) != 0);
        end
        chk("random_complete", 32'(loaded == TOT && bus.req == '0), 32'd1);
        drain();
        chk("random_grants", 32'(n_grant - gr0), 32'(loaded - dropped));
        chk("random_responses", 32'(n_hs - hs0), 32'(loaded - dropped));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
